sc_collision_sequencer: RTL and testbench

Game-level controller that time-shares a single row-versus-position hit comparator between player 1 and player 2. It sits between the obstacle-row scroller and the score/display logic. Each time the scroller reports a new bottom row, it runs one collision check per player and decrements per-player lives. It declares game over and the winner, and holds that result until restart.

---
 rtl/sc_collision_sequencer_pkg.sv | 43 ++++
 rtl/sc_colseq_hitcomp.sv | 19 +
 rtl/sc_collision_sequencer.sv | 156 +++++++++++++++
 tb/tb_sc_collision_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_collision_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sc_collision_sequencer_pkg
// Shared definitions for the collision sequencer:
//   - FSM state encoding (IDLE, CHK1, CHK2, UPD, GAMEOVER)
//   - winner codes reported on SC_COLSEQ_winner_OutBUS
//   - winnerCode(): maps "player out of lives" flags to a winner code
// -----------------------------------------------------------------------------
package sc_collision_sequencer_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CHK1     = 3'd1;
   localparam logic [2:0] ST_CHK2     = 3'd2;
   localparam logic [2:0] ST_UPD      = 3'd3;
   localparam logic [2:0] ST_GAMEOVER = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      CHK1     = ST_CHK1,
      CHK2     = ST_CHK2,
      UPD      = ST_UPD,
      GAMEOVER = ST_GAMEOVER
   } colseqState_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_J1   = 2'b01;
   localparam logic [1:0] WIN_J2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // The player who still has lives wins; both out is a draw.
   function automatic logic [1:0] winnerCode(input logic jug1Out, input logic jug2Out);
      logic [1:0] code;
      code = WIN_NONE;
      if (jug1Out && jug2Out) begin
         code = WIN_DRAW;
      end else if (jug1Out) begin
         code = WIN_J2;
      end else if (jug2Out) begin
         code = WIN_J1;
      end
      return code;
   endfunction

endpackage

// File: rtl/sc_colseq_hitcomp.sv
// -----------------------------------------------------------------------------
// sc_colseq_hitcomp
// Combinational row-versus-position hit comparator. A hit is any column where
// both the obstacle row and the player position have a set bit.
//   row  : obstacle row, 1 = obstacle
//   pos  : player position, 1 = occupied
//   hit  : 1 when row and pos share at least one set bit
// -----------------------------------------------------------------------------
module sc_colseq_hitcomp #(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH-1:0] row,
   input  logic [DATAWIDTH-1:0] pos,
   output logic                 hit
);

   assign hit = |(row & pos);

endmodule

// File: rtl/sc_collision_sequencer.sv
// -----------------------------------------------------------------------------
// sc_collision_sequencer
// Time-shares one hit comparator between two players. Each accepted start
// captures the bottom row and both positions, checks player 1 (CHK1), then
// player 2 (CHK2), then updates the saturating lives counters (UPD) and pulses
// done. When a player runs out of lives the block parks in GAMEOVER with the
// winner code until restart.
//   SC_COLSEQ_CLOCK_50          : clock
//   SC_COLSEQ_RESET_InHigh      : async active-high reset
//   SC_COLSEQ_start_InHigh      : new bottom row valid (accepted only in IDLE)
//   SC_COLSEQ_restart_InHigh    : reload lives (accepted only in GAMEOVER)
//   SC_COLSEQ_fila0_InBUS       : bottom obstacle row
//   SC_COLSEQ_posjug1/2_InBUS   : player positions
//   SC_COLSEQ_busy_Out          : sequence in progress (CHK1..UPD)
//   SC_COLSEQ_done_Out          : one-cycle pulse, hits and lives updated
//   SC_COLSEQ_hitjug1/2_Out     : registered hit results
//   SC_COLSEQ_livesjug1/2_OutBUS: lives remaining
//   SC_COLSEQ_gameover_Out      : high in GAMEOVER
//   SC_COLSEQ_winner_OutBUS     : 00 none, 01 P1, 10 P2, 11 draw
// Handshake: start is a single-cycle request with no back-pressure; a start
// that arrives outside IDLE is dropped, never queued. Software should wait for
// done (or busy low) before issuing the next start.
// -----------------------------------------------------------------------------
module sc_collision_sequencer
   import sc_collision_sequencer_pkg::*;
#(
   parameter int DATAWIDTH  = 8,
   parameter int LIVESWIDTH = 2,
   parameter int LIVES_INIT = 3
) (
   input  logic                  SC_COLSEQ_CLOCK_50,
   input  logic                  SC_COLSEQ_RESET_InHigh,
   input  logic                  SC_COLSEQ_start_InHigh,
   input  logic                  SC_COLSEQ_restart_InHigh,
   input  logic [DATAWIDTH-1:0]  SC_COLSEQ_fila0_InBUS,
   input  logic [DATAWIDTH-1:0]  SC_COLSEQ_posjug1_InBUS,
   input  logic [DATAWIDTH-1:0]  SC_COLSEQ_posjug2_InBUS,
   output logic                  SC_COLSEQ_busy_Out,
   output logic                  SC_COLSEQ_done_Out,
   output logic                  SC_COLSEQ_hitjug1_Out,
   output logic                  SC_COLSEQ_hitjug2_Out,
   output logic [LIVESWIDTH-1:0] SC_COLSEQ_livesjug1_OutBUS,
   output logic [LIVESWIDTH-1:0] SC_COLSEQ_livesjug2_OutBUS,
   output logic                  SC_COLSEQ_gameover_Out,
   output logic [1:0]            SC_COLSEQ_winner_OutBUS
);

   localparam logic [LIVESWIDTH-1:0] LIVES_RELOAD = LIVESWIDTH'(LIVES_INIT);
   localparam logic [LIVESWIDTH-1:0] LIVES_ZERO   = '0;
   localparam logic [LIVESWIDTH-1:0] LIVES_ONE    = LIVESWIDTH'(1);

   colseqState_t          state;
   logic [DATAWIDTH-1:0]  filaReg;
   logic [DATAWIDTH-1:0]  posJug1Reg;
   logic [DATAWIDTH-1:0]  posJug2Reg;
   logic [DATAWIDTH-1:0]  compPos;
   logic                  compHit;
   logic [LIVESWIDTH-1:0] livesJug1Next;
   logic [LIVESWIDTH-1:0] livesJug2Next;
   logic                  jug1Out;
   logic                  jug2Out;

   // Position mux: player 2 only in CHK2, player 1 otherwise (CHK1 is the
   // only other state where the comparator result is used).
   assign compPos = (state == CHK2) ? posJug2Reg : posJug1Reg;

   sc_colseq_hitcomp #(
      .DATAWIDTH(DATAWIDTH)
   ) u_hitcomp (
      .row(filaReg),
      .pos(compPos),
      .hit(compHit)
   );

   // Saturating decrement, evaluated from the registered hit flags in UPD.
   always_comb begin
      livesJug1Next = SC_COLSEQ_livesjug1_OutBUS;
      livesJug2Next = SC_COLSEQ_livesjug2_OutBUS;
      if (SC_COLSEQ_hitjug1_Out && (SC_COLSEQ_livesjug1_OutBUS != LIVES_ZERO)) begin
         livesJug1Next = SC_COLSEQ_livesjug1_OutBUS - LIVES_ONE;
      end
      if (SC_COLSEQ_hitjug2_Out && (SC_COLSEQ_livesjug2_OutBUS != LIVES_ZERO)) begin
         livesJug2Next = SC_COLSEQ_livesjug2_OutBUS - LIVES_ONE;
      end
   end

   assign jug1Out = (livesJug1Next == LIVES_ZERO);
   assign jug2Out = (livesJug2Next == LIVES_ZERO);

   always_ff @(posedge SC_COLSEQ_CLOCK_50 or posedge SC_COLSEQ_RESET_InHigh) begin
      if (SC_COLSEQ_RESET_InHigh) begin
         state                      <= IDLE;
         filaReg                    <= '0;
         posJug1Reg                 <= '0;
         posJug2Reg                 <= '0;
         SC_COLSEQ_busy_Out         <= 1'b0;
         SC_COLSEQ_done_Out         <= 1'b0;
         SC_COLSEQ_hitjug1_Out      <= 1'b0;
         SC_COLSEQ_hitjug2_Out      <= 1'b0;
         SC_COLSEQ_livesjug1_OutBUS <= LIVES_RELOAD;
         SC_COLSEQ_livesjug2_OutBUS <= LIVES_RELOAD;
         SC_COLSEQ_gameover_Out     <= 1'b0;
         SC_COLSEQ_winner_OutBUS    <= WIN_NONE;
      end else begin
         SC_COLSEQ_done_Out <= 1'b0;
         case (state)
            IDLE: begin
               if (SC_COLSEQ_start_InHigh) begin
                  filaReg            <= SC_COLSEQ_fila0_InBUS;
                  posJug1Reg         <= SC_COLSEQ_posjug1_InBUS;
                  posJug2Reg         <= SC_COLSEQ_posjug2_InBUS;
                  SC_COLSEQ_busy_Out <= 1'b1;
                  state              <= CHK1;
               end
            end
            CHK1: begin
               SC_COLSEQ_hitjug1_Out <= compHit;
               state                 <= CHK2;
            end
            CHK2: begin
               SC_COLSEQ_hitjug2_Out <= compHit;
               state                 <= UPD;
            end
            UPD: begin
               SC_COLSEQ_livesjug1_OutBUS <= livesJug1Next;
               SC_COLSEQ_livesjug2_OutBUS <= livesJug2Next;
               SC_COLSEQ_done_Out         <= 1'b1;
               SC_COLSEQ_busy_Out         <= 1'b0;
               if (jug1Out || jug2Out) begin
                  SC_COLSEQ_gameover_Out  <= 1'b1;
                  SC_COLSEQ_winner_OutBUS <= winnerCode(jug1Out, jug2Out);
                  state                   <= GAMEOVER;
               end else begin
                  state <= IDLE;
               end
            end
            GAMEOVER: begin
               // start is ignored here, so restart always wins a tie.
               if (SC_COLSEQ_restart_InHigh) begin
                  SC_COLSEQ_livesjug1_OutBUS <= LIVES_RELOAD;
                  SC_COLSEQ_livesjug2_OutBUS <= LIVES_RELOAD;
                  SC_COLSEQ_hitjug1_Out      <= 1'b0;
                  SC_COLSEQ_hitjug2_Out      <= 1'b0;
                  SC_COLSEQ_winner_OutBUS    <= WIN_NONE;
                  SC_COLSEQ_gameover_Out     <= 1'b0;
                  state                      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_collision_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sc_collision_sequencer
// Directed bench for sc_collision_sequencer. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the active
// rising edge.
// -----------------------------------------------------------------------------
module tb_sc_collision_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       restart;
   logic [7:0] fila0;
   logic [7:0] posJug1;
   logic [7:0] posJug2;
   logic       busy;
   logic       done;
   logic       hitJug1;
   logic       hitJug2;
   logic [1:0] livesJug1;
   logic [1:0] livesJug2;
   logic       gameover;
   logic [1:0] winner;

   int checks;
   int failures;

   // launch() observations
   int   obsDoneCnt;
   int   obsDoneAt;
   int   obsBusyCnt;
   logic obsHit1;
   logic obsHit2;

   sc_collision_sequencer #(
      .DATAWIDTH(8),
      .LIVESWIDTH(2),
      .LIVES_INIT(3)
   ) dut (
      .SC_COLSEQ_CLOCK_50(clk),
      .SC_COLSEQ_RESET_InHigh(rst),
      .SC_COLSEQ_start_InHigh(start),
      .SC_COLSEQ_restart_InHigh(restart),
      .SC_COLSEQ_fila0_InBUS(fila0),
      .SC_COLSEQ_posjug1_InBUS(posJug1),
      .SC_COLSEQ_posjug2_InBUS(posJug2),
      .SC_COLSEQ_busy_Out(busy),
      .SC_COLSEQ_done_Out(done),
      .SC_COLSEQ_hitjug1_Out(hitJug1),
      .SC_COLSEQ_hitjug2_Out(hitJug2),
      .SC_COLSEQ_livesjug1_OutBUS(livesJug1),
      .SC_COLSEQ_livesjug2_OutBUS(livesJug2),
      .SC_COLSEQ_gameover_Out(gameover),
      .SC_COLSEQ_winner_OutBUS(winner)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1;
      start = 1'b0;
      restart = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   // Pulses start for one cycle and watches six cycles. Sample i is taken
   // after rising edge k+i-1, where k is the start edge.
   task automatic launch(input logic [7:0] f, input logic [7:0] p1, input logic [7:0] p2);
      fila0 = f;
      posJug1 = p1;
      posJug2 = p2;
      start = 1'b1;
      obsDoneCnt = 0;
      obsDoneAt = 0;
      obsBusyCnt = 0;
      obsHit1 = 1'bx;
      obsHit2 = 1'bx;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (busy === 1'b1) obsBusyCnt++;
         if (done === 1'b1) begin
            obsDoneCnt++;
            if (obsDoneAt == 0) obsDoneAt = i;
         end
         if (i == 2) obsHit1 = hitJug1;
         if (i == 3) obsHit2 = hitJug2;
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if ({hitJug1, hitJug2} !== 2'b00) begin failures++; $display("FAIL reset_hits got=%b%b exp=00", hitJug1, hitJug2); end
      checks++; if ({livesJug1, livesJug2} !== {2'd3, 2'd3}) begin failures++; $display("FAIL reset_lives got=%0d/%0d exp=3/3", livesJug1, livesJug2); end
      checks++; if (gameover !== 1'b0) begin failures++; $display("FAIL reset_gameover got=%b exp=0", gameover); end
      checks++; if (winner !== 2'b00) begin failures++; $display("FAIL reset_winner got=%b exp=00", winner); end
   endtask

   task automatic test_single_hit();
      launch(8'h18, 8'h08, 8'h80);
      checks++; if (obsHit1 !== 1'b1) begin failures++; $display("FAIL single_hit1 got=%b exp=1", obsHit1); end
      checks++; if (obsHit2 !== 1'b0) begin failures++; $display("FAIL single_hit2 got=%b exp=0", obsHit2); end
      checks++; if (obsDoneAt != 4) begin failures++; $display("FAIL single_done_at got=%0d exp=4", obsDoneAt); end
      checks++; if (obsDoneCnt != 1) begin failures++; $display("FAIL single_done_cnt got=%0d exp=1", obsDoneCnt); end
      checks++; if ({livesJug1, livesJug2} !== {2'd2, 2'd3}) begin failures++; $display("FAIL single_lives got=%0d/%0d exp=2/3", livesJug1, livesJug2); end
      checks++; if (gameover !== 1'b0) begin failures++; $display("FAIL single_gameover got=%b exp=0", gameover); end
   endtask

   task automatic test_no_hit();
      launch(8'h00, 8'hFF, 8'hFF);
      checks++; if ({obsHit1, obsHit2} !== 2'b00) begin failures++; $display("FAIL nohit_hits got=%b%b exp=00", obsHit1, obsHit2); end
      checks++; if (obsBusyCnt != 3) begin failures++; $display("FAIL nohit_busy_cycles got=%0d exp=3", obsBusyCnt); end
      checks++; if (obsDoneCnt != 1) begin failures++; $display("FAIL nohit_done_cnt got=%0d exp=1", obsDoneCnt); end
      checks++; if ({livesJug1, livesJug2} !== {2'd2, 2'd3}) begin failures++; $display("FAIL nohit_lives got=%0d/%0d exp=2/3", livesJug1, livesJug2); end
   endtask

   task automatic test_start_while_busy();
      int doneCnt;
      int busyCnt;
      doneCnt = 0;
      busyCnt = 0;
      fila0 = 8'h0F;
      posJug1 = 8'h10;
      posJug2 = 8'h01;
      start = 1'b1;
      @(negedge clk);             // accepted at edge k
      if (busy === 1'b1) busyCnt++;
      start = 1'b1;               // second pulse lands on edge k+1 (CHK1)
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) doneCnt++;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busyCnt++;
         if (done === 1'b1) doneCnt++;
      end
      checks++; if (doneCnt != 1) begin failures++; $display("FAIL busy_start_done_cnt got=%0d exp=1", doneCnt); end
      checks++; if (busyCnt != 3) begin failures++; $display("FAIL busy_start_busy_cycles got=%0d exp=3", busyCnt); end
      checks++; if ({hitJug1, hitJug2} !== 2'b01) begin failures++; $display("FAIL busy_start_hits got=%b%b exp=01", hitJug1, hitJug2); end
      checks++; if ({livesJug1, livesJug2} !== {2'd2, 2'd2}) begin failures++; $display("FAIL busy_start_lives got=%0d/%0d exp=2/2", livesJug1, livesJug2); end
   endtask

   task automatic test_player1_loses();
      logic [1:0] expL1;
      apply_reset();
      expL1 = 2'd3;
      for (int n = 0; n < 3; n++) begin
         launch(8'hFF, 8'h01, 8'h00);
         expL1 = expL1 - 2'd1;
         checks++; if ({livesJug1, livesJug2} !== {expL1, 2'd3}) begin failures++; $display("FAIL p1_loses_lives round=%0d got=%0d/%0d exp=%0d/3", n, livesJug1, livesJug2, expL1); end
         checks++; if (gameover !== (n == 2)) begin failures++; $display("FAIL p1_loses_gameover round=%0d got=%b exp=%b", n, gameover, (n == 2)); end
      end
      checks++; if (winner !== 2'b10) begin failures++; $display("FAIL p1_loses_winner got=%b exp=10", winner); end
      launch(8'hFF, 8'h01, 8'h01);
      checks++; if (obsDoneCnt != 0) begin failures++; $display("FAIL gameover_start_done got=%0d exp=0", obsDoneCnt); end
      checks++; if (obsBusyCnt != 0) begin failures++; $display("FAIL gameover_start_busy got=%0d exp=0", obsBusyCnt); end
      checks++; if ({livesJug1, livesJug2, winner} !== {2'd0, 2'd3, 2'b10}) begin failures++; $display("FAIL gameover_hold got=%0d/%0d w=%b exp=0/3 w=10", livesJug1, livesJug2, winner); end
   endtask

   task automatic test_draw_and_restart();
      logic [1:0] expL;
      pulse_restart();
      checks++; if ({livesJug1, livesJug2} !== {2'd3, 2'd3}) begin failures++; $display("FAIL restart_lives got=%0d/%0d exp=3/3", livesJug1, livesJug2); end
      checks++; if ({gameover, winner} !== 3'b000) begin failures++; $display("FAIL restart_flags got=go%b w=%b exp=go0 w=00", gameover, winner); end
      checks++; if ({hitJug1, hitJug2} !== 2'b00) begin failures++; $display("FAIL restart_hits got=%b%b exp=00", hitJug1, hitJug2); end
      expL = 2'd3;
      for (int n = 0; n < 3; n++) begin
         launch(8'hFF, 8'h01, 8'h80);
         expL = expL - 2'd1;
         checks++; if ({livesJug1, livesJug2} !== {expL, expL}) begin failures++; $display("FAIL draw_lives round=%0d got=%0d/%0d exp=%0d/%0d", n, livesJug1, livesJug2, expL, expL); end
      end
      checks++; if ({gameover, winner} !== 3'b111) begin failures++; $display("FAIL draw_result got=go%b w=%b exp=go1 w=11", gameover, winner); end
      // restart and start together: restart wins, no check launched
      fila0 = 8'hFF;
      posJug1 = 8'hFF;
      posJug2 = 8'hFF;
      start = 1'b1;
      restart = 1'b1;
      @(negedge clk);
      start = 1'b0;
      restart = 1'b0;
      checks++; if ({gameover, winner, busy} !== 4'b0000) begin failures++; $display("FAIL restart_start_flags got=go%b w=%b busy=%b exp=go0 w=00 busy=0", gameover, winner, busy); end
      checks++; if ({livesJug1, livesJug2} !== {2'd3, 2'd3}) begin failures++; $display("FAIL restart_start_lives got=%0d/%0d exp=3/3", livesJug1, livesJug2); end
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL restart_start_nolaunch got=busy%b done%b exp=busy0 done0", busy, done); end
   endtask

   task automatic test_reset_mid_sequence();
      int doneCnt;
      doneCnt = 0;
      fila0 = 8'hFF;
      posJug1 = 8'h01;
      posJug2 = 8'h02;
      start = 1'b1;
      @(negedge clk);              // CHK1
      start = 1'b0;
      @(negedge clk);              // CHK2, hitjug1 already set
      rst = 1'b1;
      #1;
      checks++; if ({busy, done, hitJug1, hitJug2} !== 4'b0000) begin failures++; $display("FAIL midrst_flags got=%b%b%b%b exp=0000", busy, done, hitJug1, hitJug2); end
      checks++; if ({livesJug1, livesJug2} !== {2'd3, 2'd3}) begin failures++; $display("FAIL midrst_lives got=%0d/%0d exp=3/3", livesJug1, livesJug2); end
      checks++; if ({gameover, winner} !== 3'b000) begin failures++; $display("FAIL midrst_result got=go%b w=%b exp=go0 w=00", gameover, winner); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done === 1'b1) doneCnt++;
      end
      checks++; if (doneCnt != 0) begin failures++; $display("FAIL midrst_done_cnt got=%0d exp=0", doneCnt); end
      checks++; if ({busy, livesJug1, livesJug2} !== {1'b0, 2'd3, 2'd3}) begin failures++; $display("FAIL midrst_after got=busy%b %0d/%0d exp=busy0 3/3", busy, livesJug1, livesJug2); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      start = 1'b0;
      restart = 1'b0;
      fila0 = '0;
      posJug1 = '0;
      posJug2 = '0;
      test_reset();
      test_single_hit();
      test_no_hit();
      test_start_while_busy();
      test_player1_loses();
      test_draw_and_restart();
      test_reset_mid_sequence();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
